// File: rtl/pixel_cmp_pkg.sv
// Shared types and helpers for the sequential approximate pixel comparator.
package pixel_cmp_pkg;

  localparam int unsigned SLICE_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Number of slices actually examined after skipping the approximated LSB slices.
  function automatic int unsigned num_slices(input int unsigned pix_w,
                                             input int unsigned approx_pairs);
    return pix_w / SLICE_W - approx_pairs;
  endfunction

endpackage

// File: rtl/pixel_slice_cmp_tbac.sv
// Two-bit accurate comparator (TBAC): h_c when x > y, l_c when x < y.
module pixel_slice_cmp_tbac (
  input  logic x1,
  input  logic x0,
  input  logic y1,
  input  logic y0,
  output logic h_c,
  output logic l_c
);

  logic msb_eq;

  assign msb_eq = ~(x1 ^ y1);
  assign h_c    = (x1 & ~y1) | (msb_eq & x0 & ~y0);
  assign l_c    = (~x1 & y1) | (msb_eq & ~x0 & y0);

endmodule

// File: rtl/pixel_slice_cmp.sv
// Sequential MSB-first approximate pixel comparator, one 2-bit slice per cycle.
// Optional macro EARLY_EXIT_EN: stop at the first differing slice instead of walking all slices.
module pixel_slice_cmp
  import pixel_cmp_pkg::*;
#(
  parameter int unsigned PIX_W        = 8,
  parameter int unsigned APPROX_PAIRS = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [PIX_W-1:0]               x,
  input  logic [PIX_W-1:0]               y,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           gt,
  output logic                           lt,
  output logic                           eq,
  output logic [$clog2(PIX_W/2+1)-1:0]   cmp_cnt
);

  localparam int unsigned HALF  = PIX_W / SLICE_W;
  localparam int unsigned CNT_W = $clog2(PIX_W/2+1);
  localparam int unsigned IDX_W = CNT_W;

  if ((PIX_W % 2) != 0 || PIX_W < 2) begin : g_bad_width
    $error("pixel_slice_cmp: PIX_W must be even and at least 2");
  end
  if (APPROX_PAIRS >= HALF || num_slices(PIX_W, APPROX_PAIRS) < 1) begin : g_bad_approx
    $error("pixel_slice_cmp: APPROX_PAIRS must be below PIX_W/2");
  end

  state_e             state;
  logic [PIX_W-1:0]   sx;
  logic [PIX_W-1:0]   sy;
  logic [IDX_W-1:0]   idx;
  logic               h_c;
  logic               l_c;
  logic               gt_n_c;
  logic               lt_n_c;
  logic               last_c;

  pixel_slice_cmp_tbac u_tbac (
    .x1  (sx[PIX_W-1]),
    .x0  (sx[PIX_W-2]),
    .y1  (sy[PIX_W-1]),
    .y0  (sy[PIX_W-2]),
    .h_c (h_c),
    .l_c (l_c)
  );

  assign in_ready = (state == IDLE);

  // The first differing slice wins; later slices cannot overwrite a latched decision.
  assign gt_n_c = (gt | lt) ? gt : h_c;
  assign lt_n_c = (gt | lt) ? lt : l_c;

`ifdef EARLY_EXIT_EN
  assign last_c = h_c | l_c | (idx == IDX_W'(APPROX_PAIRS));
`else
  assign last_c = (idx == IDX_W'(APPROX_PAIRS));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sx        <= '0;
      sy        <= '0;
      idx       <= '0;
      gt        <= 1'b0;
      lt        <= 1'b0;
      eq        <= 1'b0;
      cmp_cnt   <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sx      <= x;
            sy      <= y;
            gt      <= 1'b0;
            lt      <= 1'b0;
            eq      <= 1'b0;
            cmp_cnt <= '0;
            idx     <= IDX_W'(HALF - 1);
            state   <= CMP;
          end
        end
        CMP: begin
          cmp_cnt <= cmp_cnt + CNT_W'(1);
          gt      <= gt_n_c;
          lt      <= lt_n_c;
          if (last_c) begin
            eq        <= ~gt_n_c & ~lt_n_c;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            sx  <= sx << SLICE_W;
            sy  <= sy << SLICE_W;
            idx <= idx - IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_slice_cmp.sv
// Self-checking bench for pixel_slice_cmp (PIX_W=8, APPROX_PAIRS=1); follows EARLY_EXIT_EN like the DUT.
module tb_pixel_slice_cmp;

  localparam int unsigned PIX_W = 8;
  localparam int unsigned AP    = 1;
`ifdef EARLY_EXIT_EN
  localparam bit EARLY   = 1'b1;
  localparam int M_FIRST = 1;
`else
  localparam bit EARLY   = 1'b0;
  localparam int M_FIRST = 3;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] x;
  logic [7:0] y;
  logic       out_valid;
  logic       out_ready;
  logic       gt;
  logic       lt;
  logic       eq;
  logic [2:0] cmp_cnt;

  int   errors = 0;
  int   checks = 0;
  logic exp_gt, exp_lt, exp_eq;
  int   exp_m;
  int   lat;

  always #5 clk = ~clk;

  pixel_slice_cmp #(.PIX_W(PIX_W), .APPROX_PAIRS(AP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .gt        (gt),
    .lt        (lt),
    .eq        (eq),
    .cmp_cnt   (cmp_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Reference: compare pixels slice by slice as plain integers, MSB slice first.
  function automatic void model(input int a, input int b, output logic g, output logic l,
                                output logic e, output int m);
    g = 1'b0;
    l = 1'b0;
    m = 0;
    for (int k = PIX_W/2 - 1; k >= int'(AP); k--) begin
      int sa;
      int sb;
      sa = (a >> (2*k)) & 3;
      sb = (b >> (2*k)) & 3;
      m++;
      if (!g && !l) begin
        if (sa > sb) g = 1'b1;
        else if (sa < sb) l = 1'b1;
      end
      if (EARLY && (g || l)) break;
    end
    e = !g && !l;
  endfunction

  // Whenever a result is presented it must match the model and block new input.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      check("res_gt", 32'(gt), 32'(exp_gt));
      check("res_lt", 32'(lt), 32'(exp_lt));
      check("res_eq", 32'(eq), 32'(exp_eq));
      check("res_cnt", 32'(cmp_cnt), 32'(exp_m));
      check("busy_in_ready", 32'(in_ready), 32'd0);
    end
  end

  task automatic accept(input logic [7:0] a, input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    x = a;
    y = b;
    model(int'(a), int'(b), exp_gt, exp_lt, exp_eq, exp_m);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_result(output int l);
    l = 0;
    do begin
      @(posedge clk);
      #1;
      l++;
    end while (!out_valid && l < 20);
    check("result_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("handshake_out_valid", 32'(out_valid), 32'd0);
    check("handshake_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic run(input logic [7:0] a, input logic [7:0] b, output int l);
    accept(a, b);
    wait_result(l);
    check("latency_model", 32'(l), 32'(exp_m));
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
  } pair_t;

  pair_t sweep [6] = '{
    '{8'h00, 8'h00}, '{8'hFF, 8'hFC}, '{8'hFF, 8'h00},
    '{8'h3C, 8'h34}, '{8'h0C, 8'h10}, '{8'h9A, 8'h99}
  };

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; x = '0; y = '0;
    exp_gt = 1'b0; exp_lt = 1'b0; exp_eq = 1'b0; exp_m = 0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_gt", 32'(gt), 32'd0);
    check("rst_lt", 32'(lt), 32'd0);
    check("rst_eq", 32'(eq), 32'd0);
    check("rst_cnt", 32'(cmp_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // MSB slice differs: 11 vs 01.
    run(8'hC8, 8'h40, lat);
    check("c8_gt", 32'(gt), 32'd1);
    check("c8_lt", 32'(lt), 32'd0);
    check("c8_eq", 32'(eq), 32'd0);
    check("c8_cnt", 32'(cmp_cnt), 32'(M_FIRST));
    check("c8_lat", 32'(lat), 32'(M_FIRST));

    // Stall the result while a new pair is offered; it must not be taken.
    @(negedge clk);
    in_valid = 1'b1;
    x = 8'h12;
    y = 8'h11;
    repeat (5) begin
      @(negedge clk);
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_gt", 32'(gt), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("hold_release_out_valid", 32'(out_valid), 32'd0);
    check("hold_release_in_ready", 32'(in_ready), 32'd1);
    model(32'h12, 32'h11, exp_gt, exp_lt, exp_eq, exp_m);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_result(lat);
    check("skip_eq", 32'(eq), 32'd1);
    check("skip_gt", 32'(gt), 32'd0);
    check("skip_lt", 32'(lt), 32'd0);
    check("skip_cnt", 32'(cmp_cnt), 32'd3);
    check("skip_lat", 32'(lat), 32'd3);
    release_out();

    // Third slice 01 vs 10.
    run(8'h24, 8'h28, lat);
    check("t24_lt", 32'(lt), 32'd1);
    check("t24_cnt", 32'(cmp_cnt), 32'd3);
    check("t24_lat", 32'(lat), 32'd3);
    release_out();

    // gt in slice 3, opposite direction in slice 2 must not flip it.
    run(8'h80, 8'h60, lat);
    check("sticky_gt", 32'(gt), 32'd1);
    check("sticky_lt", 32'(lt), 32'd0);
    check("sticky_cnt", 32'(cmp_cnt), 32'(M_FIRST));
    release_out();

    // Reset during the second CMP cycle.
    accept(8'h24, 8'h28);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_cnt", 32'(cmp_cnt), 32'd0);
    check("midrst_lt", 32'(lt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(8'h40, 8'hC8, lat);
    check("post_rst_lt", 32'(lt), 32'd1);
    check("post_rst_cnt", 32'(cmp_cnt), 32'(M_FIRST));
    release_out();

    foreach (sweep[i]) begin
      run(sweep[i].a, sweep[i].b, lat);
      release_out();
    end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pixel_slice_cmp.md
# pixel_slice_cmp

Sequential multi-bit approximate pixel comparator. Accepts two PIX_W-bit pixels over a valid/ready handshake and walks them MSB-first, one 2-bit slice per cycle, through the two-bit accurate comparator (TBAC). The lowest APPROX_PAIRS slices are never examined, which is the approximation. It sits directly upstream of TBAC: it feeds TBAC slices and consumes its H/L to form the pixel-level greater/less/equal result for the sorting and filter stages.

## Interface
- PIX_W, 8, pixel width in bits; must be even and ≥ 2.
- APPROX_PAIRS, 1, number of LSB 2-bit slices skipped; legal range 0..PIX_W/2-1; 0 means fully accurate.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  pixel pair x/y is valid.
- in_ready  out  1  block can accept a pair; high only in IDLE.
- x  in  PIX_W  first pixel.
- y  in  PIX_W  second pixel.
- out_valid  out  1  result is valid; high only in DONE.
- out_ready  in  1  downstream accepts the result.
- gt  out  1  x > y over the examined slices.
- lt  out  1  x < y over the examined slices.
- eq  out  1  no examined slice differed.
- cmp_cnt  out  $clog2(PIX_W/2+1)  number of slices fed to TBAC for this result.

## Operation
- FSM states: IDLE, CMP, DONE.
- Number of examinable slices: N = PIX_W/2 − APPROX_PAIRS.
- IDLE: in_ready=1. On in_valid&&in_ready, capture x and y into shift registers, clear gt/lt/cmp_cnt, load slice index = PIX_W/2−1, and go to CMP.
- CMP: drive the top 2 bits of each shift register to TBAC (X1/X0, Y1/Y0). At each edge:
  - increment cmp_cnt;
  - if TBAC H=1 and no difference has yet been latched, set gt;
  - if TBAC L=1 and no difference has yet been latched, set lt. The first differing slice decides; gt and lt are never both 1.
  - Go to DONE when the terminating condition holds (see Configuration) or when the index equals APPROX_PAIRS. Otherwise shift both registers left by 2 and decrement the index.
- DONE: out_valid=1, eq=!gt&&!lt. Outputs hold stable until out_ready=1, then go to IDLE.
- in_valid is ignored outside IDLE. x and y are sampled only at acceptance.
- Reset (any state, including mid-CMP): state=IDLE, in_ready=1, out_valid=0, gt=lt=eq=0, cmp_cnt=0, shift registers=0.

## Timing
- Acceptance edge E0. Slice k (k=1..m) is evaluated at edge Ek. out_valid rises after Em.
- Latency from acceptance to out_valid is m = cmp_cnt cycles.
- Output-handshake edge returns the FSM to IDLE. in_ready rises the following cycle. No same-cycle output→input bypass.
- Per-pair cycle count is m + 2 (IDLE, m×CMP, DONE).
- out_valid, gt, lt, eq and cmp_cnt are registered. in_ready is decoded from state.

## Configuration
- EARLY_EXIT_EN defined: CMP terminates at the first slice with H or L. m = index of the first differing slice, or N if none differs.
- EARLY_EXIT_EN undefined: all N slices are always evaluated, with the first difference latched sticky. m = N for every pair, giving constant latency.

## Structure
- Shared package pixel_cmp_pkg: state enum (IDLE/CMP/DONE), SLICE_W=2, and a function computing N from PIX_W and APPROX_PAIRS.
- One sub-module: the existing TBAC, instanced once as the slice comparator.
- Elaboration-time checks: PIX_W even; APPROX_PAIRS < PIX_W/2.

## Test plan
All scenarios use PIX_W=8, APPROX_PAIRS=1 (N=3), and EARLY_EXIT_EN defined unless stated.
- x=0xC8, y=0x40 → gt=1, lt=0, eq=0, cmp_cnt=1, out_valid 1 cycle after acceptance.
- x=0x12, y=0x11 (differ only in the skipped LSB slice) → eq=1, gt=lt=0, cmp_cnt=3.
- x=0x24, y=0x28 (third slice 01 vs 10) → lt=1, cmp_cnt=3, latency 3.
- Result 0xC8/0x40 held with out_ready=0 for 5 cycles while in_valid=1 with new data → outputs stable, in_ready=0, new pair not captured. After out_ready=1, IDLE follows and the next pair is accepted.
- rst_n pulsed low during the second CMP cycle → out_valid=0 and in_ready=1 immediately. The next pair 0x40/0xC8 yields lt=1 and cmp_cnt=1.
- EARLY_EXIT_EN undefined, x=0xC8, y=0x40 → gt=1, cmp_cnt=3, latency 3. A later slice difference (0x40 then 0x80 in slice 2 direction) does not flip gt.
